// File: rtl/alu.sv
// 4-bit, 8-operation ALU with a registered result and a carry/overflow condition code register.
// Inputs are sampled every rising edge; outputs show the previous edge's operation.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] n1,
    input  logic [3:0] n2,
    input  logic [2:0] operator,
    output logic [1:0] CCR,
    output logic [3:0] result
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    logic [3:0] result_d, result_q;
    logic       carry_d, carry_q;
    logic       ovf_d, ovf_q;

    logic [4:0] sum;
    logic [4:0] diff;
    logic [7:0] prod_u;
    logic [7:0] prod_s;
    op_e        op;

    assign op   = op_e'(operator);
    assign sum  = {1'b0, n1} + {1'b0, n2};
    assign diff = {1'b0, n1} - {1'b0, n2};
    assign prod_u = {4'b0000, n1} * {4'b0000, n2};
    // Sign-extended 8-bit multiply; the low 8 bits hold the exact signed product (-56..64).
    assign prod_s = {{4{n1[3]}}, n1} * {{4{n2[3]}}, n2};

    always_comb begin
        result_d = 4'b0000;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (op)
            OP_ADD: begin
                result_d = sum[3:0];
                carry_d  = sum[4];
                ovf_d    = (n1[3] == n2[3]) && (sum[3] != n1[3]);
            end
            OP_SUB: begin
                result_d = diff[3:0];
                carry_d  = diff[4];
                ovf_d    = (n1[3] != n2[3]) && (diff[3] != n1[3]);
            end
            OP_AND: result_d = n1 & n2;
            OP_OR:  result_d = n1 | n2;
            OP_XOR: result_d = n1 ^ n2;
            OP_SLL: begin
                result_d = {n1[2:0], 1'b0};
                carry_d  = n1[3];
                ovf_d    = n1[3] ^ n1[2];
            end
            OP_SRL: begin
                result_d = {1'b0, n1[3:1]};
                carry_d  = n1[0];
            end
            OP_MUL: begin
                result_d = prod_u[3:0];
                carry_d  = |prod_u[7:4];
                // In range -8..7 exactly when bits 7..3 are all equal.
                ovf_d    = !((&prod_s[7:3]) || !(|prod_s[7:3]));
            end
            default: begin
                result_d = 4'b0000;
                carry_d  = 1'b0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 4'b0000;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign CCR    = {carry_q, ovf_q};

endmodule

// File: tb/tb_alu.sv
// Directed and exhaustive checks of the alu: reset, flag corners, all opcodes, and a mid-sweep reset.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] n1, n2;
    logic [2:0] operator;
    logic [1:0] ccr;
    logic [3:0] result;

    int errors = 0;
    int checks = 0;
    logic [5:0] prev_exp;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .n1       (n1),
        .n2       (n2),
        .operator (operator),
        .CCR      (ccr),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got CCR=%b result=%b, want CCR=%b result=%b",
                     tag, got[5:4], got[3:0], exp[5:4], exp[3:0]);
        end
    endtask

    // Independent integer reference: {carry, overflow, result}.
    function automatic logic [5:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, s;
        logic c, v;
        logic [3:0] rr;
        ua = int'(a);
        ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        r = 0; s = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 15); s = sa + sb; v = (s > 7) || (s < -8); end
            3'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 7) || (s < -8); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * 2; c = a[3]; s = sa * 2; v = (s > 7) || (s < -8); end
            3'd6: begin r = ua / 2; c = a[0]; end
            default: begin r = ua * ub; c = (r > 15); s = sa * sb; v = (s > 7) || (s < -8); end
        endcase
        rr = r[3:0];
        return {c, v, rr};
    endfunction

    // Drive one operation mid-cycle, confirm outputs hold until the edge, then check after it.
    task automatic apply(input string tag, input logic do_rst, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic [5:0] exp);
        @(negedge clk);
        rst      = do_rst;
        operator = op;
        n1       = a;
        n2       = b;
        #1;
        check($sformatf("%s/hold", tag), {ccr, result}, prev_exp);
        @(posedge clk);
        #1;
        check(tag, {ccr, result}, exp);
        prev_exp = exp;
    endtask

    initial begin
        rst = 1'b1;
        operator = 3'b000;
        n1 = 4'b1111;
        n2 = 4'b0001;
        @(posedge clk); #1;
        check("reset_1", {ccr, result}, 6'b00_0000);
        @(posedge clk); #1;
        check("reset_2", {ccr, result}, 6'b00_0000);
        prev_exp = 6'b00_0000;

        apply("rst_release", 1'b0, 3'b000, 4'b1111, 4'b0001, 6'b10_0000);
        apply("add_ovf",     1'b0, 3'b000, 4'b0111, 4'b0001, 6'b01_1000);
        apply("sub_borrow",  1'b0, 3'b001, 4'b0000, 4'b0001, 6'b10_1111);
        apply("sub_ovf",     1'b0, 3'b001, 4'b1000, 4'b0001, 6'b01_0111);
        apply("and",         1'b0, 3'b010, 4'b1010, 4'b0110, 6'b00_0010);
        apply("or",          1'b0, 3'b011, 4'b1010, 4'b0110, 6'b00_1110);
        apply("xor",         1'b0, 3'b100, 4'b1010, 4'b0110, 6'b00_1100);
        apply("sll",         1'b0, 3'b101, 4'b1001, 4'b0110, 6'b11_0010);
        apply("srl",         1'b0, 3'b110, 4'b1001, 4'b0110, 6'b10_0100);
        apply("mul_3x5",     1'b0, 3'b111, 4'b0011, 4'b0101, 6'b01_1111);
        apply("mul_fxf",     1'b0, 3'b111, 4'b1111, 4'b1111, 6'b10_0001);
        apply("mul_zero",    1'b0, 3'b111, 4'b0000, 4'b1011, 6'b00_0000);
        apply("mul_m8xm8",   1'b0, 3'b111, 4'b1000, 4'b1000, 6'b11_0000);
        apply("sll_noovf",   1'b0, 3'b101, 4'b1100, 4'b0000, 6'b10_1000);

        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < 256; p++) begin
                logic [3:0] a, b;
                logic [2:0] o;
                o = 3'(op);
                a = 4'(p >> 4);
                b = 4'(p);
                if (op == 7 && p == 100)
                    apply("mid_reset", 1'b1, o, a, b, 6'b00_0000);
                else
                    apply($sformatf("sweep op=%0d n1=%0d n2=%0d", op, a, b), 1'b0, o, a, b, model(o, a, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
